vec_alu_seq: RTL and testbench

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

---
 rtl/vec_alu_seq_if.sv | 28 ++
 rtl/vec_alu_seq.sv | 190 +++++++++++++++++++
 tb/tb_vec_alu_seq.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_seq_if.sv
// Request/result bundle for vec_alu_seq: the requester drives the operation, the ALU returns status and result.
interface vec_alu_seq_if #(
  parameter int VLEN = 128
);
  logic            start;
  logic [5:0]      opcode;
  logic [2:0]      op_type;
  logic [2:0]      vsew;
  logic [9:0]      vl;
  logic [VLEN-1:0] vs1_in;
  logic [VLEN-1:0] vs2_in;
  logic [63:0]     scalar;
  logic [4:0]      imm;
  logic            busy;
  logic            done;
  logic            illegal;
  logic [VLEN-1:0] vd_out;

  modport master (
    output start, opcode, op_type, vsew, vl, vs1_in, vs2_in, scalar, imm,
    input  busy, done, illegal, vd_out
  );

  modport slave (
    input  start, opcode, op_type, vsew, vl, vs1_in, vs2_in, scalar, imm,
    output busy, done, illegal, vd_out
  );
endinterface

// File: rtl/vec_alu_seq.sv
// Sliced vector integer ALU: one W-bit slice per cycle, carry chained across lanes and slices.
// Define VEC_ALU_SUB_EN to add vsub/vrsub; without it those opcodes are rejected as illegal.
module vec_alu_seq #(
  parameter int VLEN       = 10'd128,
  parameter int LANE_WIDTH = 3'b011,
  parameter int NB_LANES   = 2
) (
  input logic          clk,
  input logic          resetn,
  vec_alu_seq_if.slave bus
);
  localparam int LW = 1 << LANE_WIDTH;
  localparam int W  = NB_LANES * LW;
  localparam int PW = $clog2(VLEN / W + 1);
  localparam int TW = $clog2(VLEN + 1);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_AND  = 6'b001001;
  localparam logic [5:0] OP_OR   = 6'b001010;
  localparam logic [5:0] OP_XOR  = 6'b001011;
`ifdef VEC_ALU_SUB_EN
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_RSUB = 6'b000011;
`endif
  localparam logic [2:0] OT_VV = 3'b001;
  localparam logic [2:0] OT_VX = 3'b010;
  localparam logic [2:0] OT_VI = 3'b100;

  // state  | meaning
  // S_IDLE | waiting for start; result and illegal held
  // S_RUN  | one slice per cycle until the last covered slice
  // S_DONE | single-cycle done pulse
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          state_q;
  logic            busy_q, done_q, illegal_q, carry_q;
  logic [VLEN-1:0] vd_q, vs1_q, vs2_q;
  logic [PW-1:0]   ptr_q;
  logic [TW-1:0]   tot_q;
  logic [5:0]      op_q;
  logic [2:0]      opt_q;
  logic [1:0]      sew_q;
  logic [63:0]     scalar_q;
  logic [4:0]      imm_q;

  logic            illegal_d, legal_op;
  logic [TW-1:0]   tot_d;
  int              sew_in, prod, tot_full;

  always_comb begin
    legal_op = 1'b0;
    case (bus.opcode)
      OP_ADD, OP_AND, OP_OR, OP_XOR: legal_op = 1'b1;
`ifdef VEC_ALU_SUB_EN
      OP_SUB:  legal_op = 1'b1;
      OP_RSUB: legal_op = (bus.op_type != OT_VV);
`endif
      default: legal_op = 1'b0;
    endcase
    sew_in    = 8 << bus.vsew[1:0];
    illegal_d = !legal_op || (bus.vsew > 3'd3) || (sew_in < LW);
    prod      = int'(bus.vl) * sew_in;
    // Clamp to the number of whole elements that fit in the register
    tot_full  = (prod > VLEN) ? (VLEN / sew_in) * sew_in : prod;
    tot_d     = TW'(tot_full);
  end

  logic [W-1:0]    slice_d;
  logic            carry_d, cin, cin_el, arith;
  logic [LW-1:0]   a, b, x, y, r;
  logic [LW:0]     s;
  logic [63:0]     imm_ext;
  int              off, eoff, sew_run;

  always_comb begin
    slice_d = '0;
    carry_d = carry_q;
    cin     = carry_q;
    cin_el  = 1'b0;
    a = '0; b = '0; x = '0; y = '0; r = '0; s = '0;
    off = 0; eoff = 0;
    sew_run = 8 << sew_q;
    imm_ext = {{59{imm_q[4]}}, imm_q};
    arith   = (op_q == OP_ADD);
`ifdef VEC_ALU_SUB_EN
    arith   = arith || (op_q == OP_SUB) || (op_q == OP_RSUB);
`endif
    for (int l = 0; l < NB_LANES; l++) begin
      off  = int'(ptr_q) * W + l * LW;
      eoff = off & (sew_run - 1);
      a    = LW'(vs2_q >> off);
      if (opt_q == OT_VX)      b = LW'(scalar_q >> eoff);
      else if (opt_q == OT_VI) b = LW'(imm_ext >> eoff);
      else                     b = LW'(vs1_q >> off);
`ifdef VEC_ALU_SUB_EN
      if (op_q == OP_SUB)       begin x = a; y = ~b; cin_el = 1'b1; end
      else if (op_q == OP_RSUB) begin x = b; y = ~a; cin_el = 1'b1; end
      else                      begin x = a; y = b;  cin_el = 1'b0; end
`else
      x = a; y = b; cin_el = 1'b0;
`endif
      if (eoff == 0) cin = cin_el;
      s = {1'b0, x} + {1'b0, y} + {{LW{1'b0}}, cin};
      if (arith) begin
        r   = s[LW-1:0];
        cin = s[LW];
      end else if (op_q == OP_AND) r = a & b;
      else if (op_q == OP_OR)      r = a | b;
      else                         r = a ^ b;
      if (off >= int'(tot_q)) r = '0;
      else r = r & ~({LW{1'b1}} << (int'(tot_q) - off));
      slice_d = slice_d | (W'(r) << (l * LW));
    end
    if (arith) carry_d = cin;
  end

  logic last_slice;
  assign last_slice = ((int'(ptr_q) + 1) * W) >= int'(tot_q);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      vd_q      <= '0;
      carry_q   <= 1'b0;
      ptr_q     <= '0;
      tot_q     <= '0;
      op_q      <= '0;
      opt_q     <= '0;
      sew_q     <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      scalar_q  <= '0;
      imm_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q      <= bus.opcode;
            opt_q     <= bus.op_type;
            sew_q     <= bus.vsew[1:0];
            vs1_q     <= bus.vs1_in;
            vs2_q     <= bus.vs2_in;
            scalar_q  <= bus.scalar;
            imm_q     <= bus.imm;
            tot_q     <= tot_d;
            vd_q      <= '0;
            illegal_q <= illegal_d;
            ptr_q     <= '0;
            carry_q   <= 1'b0;
            busy_q    <= 1'b1;
            if (illegal_d || (tot_d == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          vd_q    <= vd_q | (VLEN'(slice_d) << (int'(ptr_q) * W));
          carry_q <= carry_d;
          ptr_q   <= ptr_q + 1'b1;
          if (last_slice) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.illegal = illegal_q;
  assign bus.vd_out  = vd_q;
endmodule

// File: tb/tb_vec_alu_seq.sv
// Randomized bench for vec_alu_seq with an element-level reference model and a per-cycle compare process.
module tb_vec_alu_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  vec_alu_seq_if #(.VLEN(128)) bus ();

  vec_alu_seq #(.VLEN(128), .LANE_WIDTH(3), .NB_LANES(2)) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endfunction

  // Element-level reference: result per element with plain arithmetic mod 2^SEW
  function automatic void model(input logic [5:0] op, input logic [2:0] opt, input logic [2:0] vsew,
                                input logic [9:0] vl, input logic [127:0] v1, input logic [127:0] v2,
                                input logic [63:0] sc, input logic [4:0] im,
                                output logic [127:0] vd, output bit ill, output int n);
    int sew, vle;
    bit legal;
    longint unsigned mask, ea, eb, er;
    logic [63:0] sext;
    vd = '0; n = 0; sew = 8;
    legal = (op == 6'h00) || (op == 6'h09) || (op == 6'h0A) || (op == 6'h0B);
`ifdef VEC_ALU_SUB_EN
    legal = legal || (op == 6'h02) || (op == 6'h03 && opt != 3'b001);
`endif
    if (vsew > 3) legal = 0;
    else sew = 8 << vsew;
    ill = !legal;
    if (ill) return;
    vle  = (int'(vl) * sew > 128) ? 128 / sew : int'(vl);
    mask = (sew == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << sew) - 1);
    sext = {{59{im[4]}}, im};
    for (int e = 0; e < vle; e++) begin
      ea = 64'(v2 >> (e * sew)) & mask;
      if (opt == 3'b010)      eb = sc & mask;
      else if (opt == 3'b100) eb = sext & mask;
      else                    eb = 64'(v1 >> (e * sew)) & mask;
      case (op)
        6'h00:   er = ea + eb;
        6'h02:   er = ea - eb;
        6'h03:   er = eb - ea;
        6'h09:   er = ea & eb;
        6'h0A:   er = ea | eb;
        default: er = ea ^ eb;
      endcase
      vd = vd | (128'(er & mask) << (e * sew));
    end
    n = (vle * sew + 15) / 16;
  endfunction

  // Timeline of the model: busy from the accepted start, done N edges later, held result in idle
  bit           m_busy = 0, m_done = 0, m_ill = 0;
  int           m_left = 0;
  logic [127:0] m_vd = '0;

  always @(posedge clk or negedge resetn) begin
    logic [127:0] nv;
    bit ni;
    int nn;
    if (!resetn) begin
      m_busy = 0; m_done = 0; m_left = 0; m_vd = '0; m_ill = 0;
    end else if (m_done) begin
      m_done = 0; m_busy = 0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (bus.start) begin
      model(bus.opcode, bus.op_type, bus.vsew, bus.vl, bus.vs1_in, bus.vs2_in, bus.scalar, bus.imm, nv, ni, nn);
      m_vd = nv; m_ill = ni; m_left = nn; m_busy = 1; m_done = (nn == 0);
    end
  end

  always @(negedge clk) begin
    chk("busy", 128'(bus.busy), 128'(m_busy));
    chk("done", 128'(bus.done), 128'(m_done));
    if (m_done || !m_busy) begin
      chk("vd_out", bus.vd_out, m_vd);
      chk("illegal", 128'(bus.illegal), 128'(m_ill));
    end
  end

  task automatic run_op(input logic [5:0] op, input logic [2:0] opt, input logic [2:0] vsew,
                        input logic [9:0] vl, input logic [127:0] v1, input logic [127:0] v2,
                        input logic [63:0] sc, input logic [4:0] im, input int hold, output int lat);
    @(negedge clk);
    bus.opcode = op; bus.op_type = opt; bus.vsew = vsew; bus.vl = vl;
    bus.vs1_in = v1; bus.vs2_in = v2; bus.scalar = sc; bus.imm = im;
    bus.start = 1'b1;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k >= hold) bus.start = 1'b0;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 40 cycles (got none, expected a pulse)");
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
  endtask

  logic [127:0] mv;
  bit           mi;
  int           mn, lat;
  logic [5:0]   ops [6] = '{6'h00, 6'h02, 6'h03, 6'h09, 6'h0A, 6'h0B};

  initial begin
    logic [5:0] op;
    logic [2:0] opt, vs;
    logic [9:0] vl;
    bus.start = 0; bus.opcode = 0; bus.op_type = 3'b001; bus.vsew = 0; bus.vl = 0;
    bus.vs1_in = '0; bus.vs2_in = '0; bus.scalar = '0; bus.imm = '0;

    repeat (3) @(negedge clk);
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_vd", bus.vd_out, 128'd0);
    chk("reset_illegal", 128'(bus.illegal), 128'd0);
    #2 resetn = 1'b1;

    // vadd.vv SEW=32: per-element carry must not leak
    model(6'h00, 3'b001, 3'd2, 10'd4, {4{32'h1}}, {4{32'hFFFF_FFFF}}, 64'd0, 5'd0, mv, mi, mn);
    chk("pin_vadd32_vd", mv, 128'd0);
    chk("pin_vadd32_n", 128'(mn), 128'd8);
    run_op(6'h00, 3'b001, 3'd2, 10'd4, {4{32'h1}}, {4{32'hFFFF_FFFF}}, 64'd0, 5'd0, 1, lat);
    chk("vadd32_latency", 128'(lat), 128'd9);
    chk("vadd32_vd", bus.vd_out, 128'd0);

    // vadd.vx SEW=64: carry crosses lane and slice boundaries inside an element
    model(6'h00, 3'b010, 3'd3, 10'd2, '0, {2{64'h0000_0000_FFFF_FFFF}}, 64'd1, 5'd0, mv, mi, mn);
    chk("pin_vadd64_vd", mv, {2{64'h0000_0001_0000_0000}});
    run_op(6'h00, 3'b010, 3'd3, 10'd2, '0, {2{64'h0000_0000_FFFF_FFFF}}, 64'd1, 5'd0, 1, lat);
    chk("vadd64_vd", bus.vd_out, {2{64'h0000_0001_0000_0000}});

    // vxor.vi SEW=8 with tail in a partially covered slice
    model(6'h0B, 3'b100, 3'd0, 10'd3, '0, {104'hA5A5_A5A5, 24'h563412}, 64'd0, 5'b11111, mv, mi, mn);
    chk("pin_vxor8_vd", mv, 128'h00A9CBED);
    chk("pin_vxor8_n", 128'(mn), 128'd2);
    run_op(6'h0B, 3'b100, 3'd0, 10'd3, '0, {104'hA5A5_A5A5, 24'h563412}, 64'd0, 5'b11111, 1, lat);
    chk("vxor8_vd", bus.vd_out, 128'h00A9CBED);
    chk("vxor8_latency", 128'(lat), 128'd3);

    // Illegal opcode and vl=0 both finish on the next cycle
    run_op(6'h3F, 3'b001, 3'd0, 10'd5, '1, '1, 64'd0, 5'd0, 2, lat);
    chk("illegal_latency", 128'(lat), 128'd1);
    chk("illegal_flag", 128'(bus.illegal), 128'd1);
    chk("illegal_vd", bus.vd_out, 128'd0);
    run_op(6'h00, 3'b001, 3'd0, 10'd0, '1, '1, 64'd0, 5'd0, 1, lat);
    chk("vl0_latency", 128'(lat), 128'd1);
    chk("vl0_flag", 128'(bus.illegal), 128'd0);

    // vsub.vv SEW=16
    run_op(6'h02, 3'b001, 3'd1, 10'd1, 128'h1, 128'h0, 64'd0, 5'd0, 1, lat);
`ifdef VEC_ALU_SUB_EN
    chk("vsub16_vd", bus.vd_out, 128'h0000_FFFF);
`else
    chk("vsub16_illegal", 128'(bus.illegal), 128'd1);
`endif

    // Reset during the third RUN cycle, then a fresh vadd right after release
    @(negedge clk);
    bus.opcode = 6'h00; bus.op_type = 3'b001; bus.vsew = 3'd0; bus.vl = 10'd16;
    bus.vs1_in = {16{8'h11}}; bus.vs2_in = {16{8'h22}};
    bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_done", 128'(bus.done), 128'd0);
    chk("midrst_vd", bus.vd_out, 128'd0);
    @(negedge clk);
    @(negedge clk);
    #2 resetn = 1'b1;
    bus.vs1_in = {16{8'h01}}; bus.vs2_in = {16{8'hFF}}; bus.vl = 10'd5;
    bus.start = 1'b1;
    @(negedge clk);
    chk("postrst_busy", 128'(bus.busy), 128'd1);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("postrst_vd", bus.vd_out, 128'd0);

    for (int it = 0; it < 80; it++) begin
      op  = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      opt = 3'b001 << $urandom_range(0, 2);
      vs  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      vl  = ($urandom_range(0, 5) == 0) ? 10'($urandom) : 10'($urandom_range(0, 20));
      run_op(op, opt, vs, vl, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom},
             5'($urandom), $urandom_range(1, 2), lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
